// File: rtl/gate_plant_if.sv
// -----------------------------------------------------------------------------
// gate_plant_if
// Connection bundle between the gate controller (master) and the gate plant
// model (slave). Signal names are written from the plant's point of view:
//   abrir_i   open command from the controller
//   fechar_i  close command from the controller
//   obst_i    obstruction sensor (only used by the plant when
//             GATE_PLANT_OBST_EN is defined)
//   fca_o     open limit switch
//   fcc_o     closed limit switch
//   pos_o     current gate position (POS_W bits)
//   moving_o  motor running in either direction
//   fault_o   illegal simultaneous open/close seen
// -----------------------------------------------------------------------------
interface gate_plant_if #(
  parameter int POS_W = 4
);
  logic             abrir_i;
  logic             fechar_i;
  logic             obst_i;
  logic             fca_o;
  logic             fcc_o;
  logic [POS_W-1:0] pos_o;
  logic             moving_o;
  logic             fault_o;

  // Controller side: drives commands, reads switches and status.
  modport master (
    output abrir_i, fechar_i, obst_i,
    input  fca_o, fcc_o, pos_o, moving_o, fault_o
  );

  // Plant side: reads commands, drives switches and status.
  modport slave (
    input  abrir_i, fechar_i, obst_i,
    output fca_o, fcc_o, pos_o, moving_o, fault_o
  );
endinterface

// File: rtl/gate_plant.sv
// -----------------------------------------------------------------------------
// gate_plant
// Cycle-based behavioural model of a gate motor with its two limit switches.
// It takes the controller's open/close commands and produces the limit-switch
// and status signals the controller reads. Gate position is a counter between
// 0 (fully closed) and TRAVEL_CYCLES (fully open); dropping a command while
// moving engages the brake (FREIO) for DEAD_CYCLES cycles; open and close
// asserted together latch the FALHA state until both are released.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     gate_plant_if.slave: abrir_i, fechar_i, obst_i in;
//           fca_o, fcc_o, pos_o, moving_o, fault_o out
//
// Configuration macro:
//   GATE_PLANT_OBST_EN  when defined, obst_i high while moving freezes the
//                       position for that edge (state and moving_o kept).
//                       When undefined obst_i is ignored.
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module gate_plant #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int POS_W         = 4,
  parameter int DEAD_CYCLES   = 2,
  parameter int RESET_POS     = 4
) (
  input logic         clk_i,
  input logic         rst_ni,
  gate_plant_if.slave bus
);

  localparam int DEAD_W = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES + 1);

  localparam logic [POS_W-1:0]  TRAVEL_POS = POS_W'(TRAVEL_CYCLES);
  localparam logic [POS_W-1:0]  RST_POS    = POS_W'(RESET_POS);
  localparam logic [POS_W-1:0]  POS_ZERO   = POS_W'(0);
  localparam logic [POS_W-1:0]  POS_ONE    = POS_W'(1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD  = DEAD_W'(DEAD_CYCLES);
  localparam logic [DEAD_W-1:0] DEAD_ZERO  = DEAD_W'(0);
  localparam logic [DEAD_W-1:0] DEAD_ONE   = DEAD_W'(1);

  // Limit switches at reset follow the reset position.
  localparam logic RST_FCA = (RESET_POS == TRAVEL_CYCLES) ? 1'b1 : 1'b0;
  localparam logic RST_FCC = (RESET_POS == 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    ABRINDO  = 3'd1,
    FECHANDO = 3'd2,
    FREIO    = 3'd3,
    FALHA    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_q,   pos_d;
  logic [DEAD_W-1:0] dead_q,  dead_d;
  logic              fca_q,   fca_d;
  logic              fcc_q,   fcc_d;
  logic              moving_q, moving_d;
  logic              fault_q, fault_d;
  logic              obst_s;

`ifdef GATE_PLANT_OBST_EN
  assign obst_s = bus.obst_i;
`else
  // Obstruction input deliberately not used in this build.
  logic unused_obst_s;
  assign unused_obst_s = bus.obst_i;
  assign obst_s        = 1'b0;
`endif

  // Next-state, position, brake counter and decoded status.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dead_d  = dead_q;

    if (bus.abrir_i && bus.fechar_i) begin
      // Both commands at once is illegal in every state; position frozen.
      state_d = FALHA;
    end else begin
      case (state_q)
        PARADO: begin
          // Commands pointing into a limit are ignored.
          if (bus.abrir_i && (pos_q < TRAVEL_POS)) begin
            state_d = ABRINDO;
          end else if (bus.fechar_i && (pos_q > POS_ZERO)) begin
            state_d = FECHANDO;
          end else begin
            state_d = PARADO;
          end
        end

        ABRINDO: begin
          if (!bus.abrir_i) begin
            state_d = FREIO;
            dead_d  = DEAD_LOAD;
          end else if (obst_s) begin
            state_d = ABRINDO;
          end else if (pos_q >= TRAVEL_POS) begin
            // Cannot be reached through legal transitions; keeps pos in range.
            state_d = PARADO;
          end else begin
            pos_d = pos_q + POS_ONE;
            // Open limit switch cuts the motor on the edge it is reached.
            if ((pos_q + POS_ONE) == TRAVEL_POS) begin
              state_d = PARADO;
            end else begin
              state_d = ABRINDO;
            end
          end
        end

        FECHANDO: begin
          if (!bus.fechar_i) begin
            state_d = FREIO;
            dead_d  = DEAD_LOAD;
          end else if (obst_s) begin
            state_d = FECHANDO;
          end else if (pos_q == POS_ZERO) begin
            // Cannot be reached through legal transitions; prevents wrap.
            state_d = PARADO;
          end else begin
            pos_d = pos_q - POS_ONE;
            if ((pos_q - POS_ONE) == POS_ZERO) begin
              state_d = PARADO;
            end else begin
              state_d = FECHANDO;
            end
          end
        end

        FREIO: begin
          // Leaving on the edge where the counter reads 1 gives exactly
          // DEAD_CYCLES cycles of braking.
          if (dead_q <= DEAD_ONE) begin
            state_d = PARADO;
            dead_d  = DEAD_ZERO;
          end else begin
            state_d = FREIO;
            dead_d  = dead_q - DEAD_ONE;
          end
        end

        FALHA: begin
          if (!bus.abrir_i && !bus.fechar_i) begin
            state_d = PARADO;
          end else begin
            state_d = FALHA;
          end
        end

        default: begin
          // Illegal encoding recovers to a safe stop.
          state_d = PARADO;
          dead_d  = DEAD_ZERO;
        end
      endcase
    end

    // Status flops are loaded from the next state/position so they line up
    // with state_q/pos_q on the same cycle.
    fca_d    = (pos_d == TRAVEL_POS);
    fcc_d    = (pos_d == POS_ZERO);
    moving_d = (state_d == ABRINDO) || (state_d == FECHANDO);
    fault_d  = (state_d == FALHA);
  end

  // State, position, brake counter and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= PARADO;
      pos_q    <= RST_POS;
      dead_q   <= DEAD_ZERO;
      fca_q    <= RST_FCA;
      fcc_q    <= RST_FCC;
      moving_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dead_q   <= dead_d;
      fca_q    <= fca_d;
      fcc_q    <= fcc_d;
      moving_q <= moving_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.pos_o    = pos_q;
  assign bus.fca_o    = fca_q;
  assign bus.fcc_o    = fcc_q;
  assign bus.moving_o = moving_q;
  assign bus.fault_o  = fault_q;

endmodule
